ysyx_25040118_lsu: RTL and testbench

Load/store unit directly downstream of the EXU. It takes a memory operation (EXU-computed address, store data, funct3, rd) over a valid/ready handshake and runs a single bus transaction with byte-lane masking. It then returns a sign/zero-extended writeback to the register file, plus an error code. It turns the single-cycle core's memory access into a multi-cycle, stall-capable operation.

---
 rtl/ysyx_25040118_lsu_pkg.sv | 43 ++++
 rtl/ysyx_25040118_lsu_lane.sv | 48 ++++
 rtl/ysyx_25040118_lsu.sv | 144 ++++++++++++++
 tb/tb_ysyx_25040118_lsu.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040118_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 values, FSM states,
// error codes and the latched memory-op record.
package ysyx_25040118_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FUNCT3   = 2'd2;
  localparam logic [1:0] ERR_BUS      = 2'd3;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_op_t;

  function automatic logic lsu_f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_SW);
    return (f3 == 3'd3) || (f3 > F3_LHU);
  endfunction

  // Halfword ops have funct3[1:0]=01, word ops 10, for both loads and stores.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) || ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_25040118_lsu_lane.sv
// Byte-lane steering: store mask/data replication and load extraction with
// sign or zero extension. Purely combinational.
module ysyx_25040118_lsu_lane
  import ysyx_25040118_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_funct3)
      F3_SB:   o_wmask = 4'b0001 << i_addr;
      F3_SH:   o_wmask = 4'b0011 << {i_addr[1], 1'b0};
      F3_SW:   o_wmask = 4'hF;
      default: o_wmask = 4'h0;
    endcase
  end

  // Replicate the source so whichever lanes are enabled see the right bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign o_wdata[8*gi +: 8] = (i_funct3 == F3_SB) ? i_wdata[7:0] :
                                (i_funct3 == F3_SH) ? i_wdata[8*(gi%2) +: 8] :
                                                      i_wdata[8*gi +: 8];
  end

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LW:   o_rdata = i_rdata;
      F3_LBU:  o_rdata = {24'h0, w_byte};
      F3_LHU:  o_rdata = {16'h0, w_half};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_25040118_lsu.sv
// Load/store unit: accepts one memory op from the EXU, runs a single bus
// transaction with a timeout, and returns an extended writeback plus error code.
module ysyx_25040118_lsu
  import ysyx_25040118_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  err_code
);

  // The counter is cleared on acceptance, so the op is abandoned on the cycle
  // it reads TIMEOUT_CYCLES-2 and wb_valid lands TIMEOUT_CYCLES after accept.
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  lsu_op_t          r_op;
  logic             r_wb_wen;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic [1:0]       r_err;

  lsu_op_t          w_op_in;
  logic             w_illegal;
  logic             w_misal;
  logic             w_timeout;
  logic [3:0]       w_wmask;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_data;

  assign w_op_in = '{is_load: req_is_load, is_store: req_is_store, funct3: req_funct3,
                     rd: req_rd, addr: req_addr, wdata: req_wdata};

  assign w_illegal = lsu_f3_illegal(req_is_store, req_funct3);
  assign w_misal   = lsu_misaligned(req_funct3, req_addr[1:0]);
  assign w_timeout = (r_cnt >= L_TO_LAST);

  ysyx_25040118_lsu_lane u_lane (
    .i_funct3 (r_op.funct3),
    .i_addr   (r_op.addr[1:0]),
    .i_wdata  (r_op.wdata),
    .i_rdata  (mem_rsp_rdata),
    .o_wmask  (w_wmask),
    .o_wdata  (w_wdata),
    .o_rdata  (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_wb_wen  <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'h0;
      r_err     <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op  <= w_op_in;
            r_cnt <= '0;
            if (w_illegal || w_misal) begin
              r_state   <= S_DONE;
              r_err     <= w_illegal ? ERR_FUNCT3 : ERR_MISALIGN;
              r_wb_rd   <= req_rd;
              r_wb_data <= 32'h0;
              r_wb_wen  <= 1'b0;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_req_ready) begin
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_err     <= ERR_BUS;
            r_wb_rd   <= r_op.rd;
            r_wb_data <= 32'h0;
            r_wb_wen  <= 1'b0;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_rsp_valid) begin
            r_state   <= S_DONE;
            r_err     <= mem_rsp_err ? ERR_BUS : ERR_OK;
            r_wb_rd   <= r_op.rd;
            r_wb_data <= (r_op.is_load && !mem_rsp_err) ? w_load_data : 32'h0;
            r_wb_wen  <= r_op.is_load && (r_op.rd != 5'd0) && !mem_rsp_err;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_err     <= ERR_BUS;
            r_wb_rd   <= r_op.rd;
            r_wb_data <= 32'h0;
            r_wb_wen  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_wen   = r_op.is_store;
  assign mem_req_addr  = {r_op.addr[31:2], 2'b00};
  assign mem_req_wdata = w_wdata;
  assign mem_req_wmask = r_op.is_store ? w_wmask : 4'h0;

  assign wb_valid = (r_state == S_DONE);
  assign wb_wen   = wb_valid & r_wb_wen;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign err_code = r_err;

endmodule

// File: tb/tb_ysyx_25040118_lsu.sv
// Scenario bench for the LSU: a configurable bus model plus a scoreboard of
// expected writebacks popped when wb_valid appears.
module tb_ysyx_25040118_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err_code;

  ysyx_25040118_lsu #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  typedef struct {
    int          lat;
    bit          got;
    bit          saw_req;
    bit          stable;
    int          req_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        wb_wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  err;
  } obs_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Bus model knobs
  int          bus_ready_delay = 0;
  int          bus_rsp_delay = 0;
  bit          bus_silent = 0;
  bit          bus_err_i = 0;
  logic [31:0] bus_rdata = 32'h0;
  int          b_wait = 0;
  int          b_cnt = 0;
  bit          b_pend = 0;
  bit          b_vld = 0;
  bit          b_hs = 0;

  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    mem_rsp_err   = 1'b0;
  end

  // Sample the request at negedge, answer just after the following posedge.
  always begin
    @(negedge clk);
    b_vld = mem_req_valid;
    b_hs  = mem_req_valid && mem_req_ready;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    if (b_pend) begin
      if (b_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = bus_rdata;
        mem_rsp_err   = bus_err_i;
        b_pend = 0;
      end else begin
        b_cnt--;
      end
    end
    if (b_hs) begin
      b_wait = 0;
      if (!bus_silent) begin
        if (bus_rsp_delay == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = bus_rdata;
          mem_rsp_err   = bus_err_i;
        end else begin
          b_pend = 1;
          b_cnt  = bus_rsp_delay - 1;
        end
      end
    end else if (b_vld) begin
      b_wait++;
    end else begin
      b_wait = 0;
    end
    mem_req_ready = (b_wait >= bus_ready_delay);
  end

  task automatic drive_req(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_is_store = !ld;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(output obs_t o);
    o = '{default: 0};
    o.stable = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (!o.saw_req) begin
          o.addr = mem_req_addr; o.wdata = mem_req_wdata;
          o.wmask = mem_req_wmask; o.wen = mem_req_wen;
        end else if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !==
                     {o.addr, o.wdata, o.wmask, o.wen}) begin
          o.stable = 0;
        end
        o.saw_req = 1;
        o.req_cycles++;
      end
      if (wb_valid) begin
        o.got = 1; o.lat = i; o.wb_wen = wb_wen;
        o.rd = wb_rd; o.data = wb_data; o.err = err_code;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, mem_req_valid, wb_valid, wb_wen} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b exp 1000", {req_ready, mem_req_valid, wb_valid, wb_wen});
    else n_pass++;
    n_checks++;
    if ({wb_rd, wb_data, err_code} !== 39'h0)
      $display("FAIL reset_regs: got rd=%0d data=%h err=%0d exp zeros", wb_rd, wb_data, err_code);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_load_lb();
    obs_t o; exp_t e;
    bus_rdata = 32'h80AABBCC; bus_err_i = 0;
    sb.push_back('{rd: 5'd10, data: 32'hFFFFFF80, wen: 1'b1, err: 2'd0, lat: 3});
    drive_req(1, 3'd0, 32'h80000003, 32'h0, 5'd10);
    wait_wb(o);
    e = sb.pop_front();
    n_checks++;
    if ({o.addr, o.wmask, o.wen} !== {32'h80000000, 4'h0, 1'b0})
      $display("FAIL lb_req: got addr=%h mask=%h wen=%b exp 80000000/0/0", o.addr, o.wmask, o.wen);
    else n_pass++;
    n_checks++;
    if (o.lat !== e.lat) $display("FAIL lb_latency: got %0d exp %0d", o.lat, e.lat);
    else n_pass++;
    n_checks++;
    if ({o.data, o.wb_wen, o.rd, o.err} !== {e.data, e.wen, e.rd, e.err})
      $display("FAIL lb_wb: got data=%h wen=%b rd=%0d err=%0d exp data=%h wen=%b rd=%0d err=%0d",
               o.data, o.wb_wen, o.rd, o.err, e.data, e.wen, e.rd, e.err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) $display("FAIL lb_pulse: got wb_valid=%b exp 0", wb_valid);
    else n_pass++;
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3[5]  = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
    logic [31:0] ad[5]  = '{32'h80000002, 32'h80000001, 32'h80000008, 32'h80000004, 32'h80000007};
    logic [31:0] wd[5]  = '{32'h1234ABCD, 32'h0000005A, 32'hDEADBEEF, 32'h00001357, 32'h000000C3};
    logic [3:0]  em[5]  = '{4'b1100, 4'b0010, 4'b1111, 4'b0011, 4'b1000};
    logic [31:0] ew[5]  = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h13571357, 32'hC3C3C3C3};
    obs_t o; exp_t e;
    for (int i = 0; i < 5; i++) begin
      bus_rdata = 32'hFFFFFFFF;
      sb.push_back('{rd: 5'd5, data: 32'h0, wen: 1'b0, err: 2'd0, lat: 3});
      drive_req(0, f3[i], ad[i], wd[i], 5'd5);
      wait_wb(o);
      e = sb.pop_front();
      n_checks++;
      if ({o.wmask, o.wdata, o.wen, o.addr} !== {em[i], ew[i], 1'b1, ad[i] & 32'hFFFFFFFC})
        $display("FAIL store_req[%0d]: got mask=%b wdata=%h wen=%b addr=%h exp mask=%b wdata=%h wen=1 addr=%h",
                 i, o.wmask, o.wdata, o.wen, o.addr, em[i], ew[i], ad[i] & 32'hFFFFFFFC);
      else n_pass++;
      n_checks++;
      if ({o.lat, o.data, o.wb_wen, o.err} !== {e.lat, e.data, e.wen, e.err})
        $display("FAIL store_wb[%0d]: got lat=%0d data=%h wen=%b err=%0d exp lat=%0d data=%h wen=%b err=%0d",
                 i, o.lat, o.data, o.wb_wen, o.err, e.lat, e.data, e.wen, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3[6] = '{3'd1, 3'd1, 3'd4, 3'd0, 3'd2, 3'd5};
    logic [31:0] ad[6] = '{32'h10000002, 32'h10000000, 32'h10000001, 32'h10000000, 32'h10000004, 32'h10000000};
    logic [31:0] rd_w[6] = '{32'h80011234, 32'h80011234, 32'h1122F133, 32'h1122F17F, 32'hCAFEF00D, 32'h0000FEDC};
    logic [31:0] ex[6] = '{32'hFFFF8001, 32'h00001234, 32'h000000F1, 32'h0000007F, 32'hCAFEF00D, 32'h0000FEDC};
    logic [4:0]  rr[6] = '{5'd3, 5'd31, 5'd4, 5'd9, 5'd0, 5'd17};
    obs_t o; exp_t e;
    for (int i = 0; i < 6; i++) begin
      bus_rdata = rd_w[i];
      sb.push_back('{rd: rr[i], data: ex[i], wen: (rr[i] != 5'd0), err: 2'd0, lat: 3});
      drive_req(1, f3[i], ad[i], 32'h0, rr[i]);
      wait_wb(o);
      e = sb.pop_front();
      n_checks++;
      if ({o.lat, o.data, o.wb_wen, o.rd, o.err, o.wmask} !== {e.lat, e.data, e.wen, e.rd, e.err, 4'h0})
        $display("FAIL load_ext[%0d]: got lat=%0d data=%h wen=%b rd=%0d err=%0d mask=%h exp lat=%0d data=%h wen=%b rd=%0d err=%0d mask=0",
                 i, o.lat, o.data, o.wb_wen, o.rd, o.err, o.wmask, e.lat, e.data, e.wen, e.rd, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    bit          ld[7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [2:0]  f3[7] = '{3'd2, 3'd1, 3'd5, 3'd3, 3'd7, 3'd3, 3'd2};
    logic [31:0] ad[7] = '{32'h80000001, 32'h80000003, 32'h80000001, 32'h80000000,
                           32'h80000001, 32'h80000000, 32'h80000002};
    logic [1:0]  ee[7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    obs_t o; exp_t e;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{rd: 5'd6, data: 32'h0, wen: 1'b0, err: ee[i], lat: 1});
      drive_req(ld[i], f3[i], ad[i], 32'h55555555, 5'd6);
      wait_wb(o);
      e = sb.pop_front();
      n_checks++;
      if ({o.lat, o.saw_req, o.err, o.data, o.wb_wen, o.rd} !== {e.lat, 1'b0, e.err, e.data, e.wen, e.rd})
        $display("FAIL error[%0d]: got lat=%0d bus=%b err=%0d data=%h wen=%b rd=%0d exp lat=%0d bus=0 err=%0d data=%h wen=%b rd=%0d",
                 i, o.lat, o.saw_req, o.err, o.data, o.wb_wen, o.rd, e.lat, e.err, e.data, e.wen, e.rd);
      else n_pass++;
    end
  endtask

  task automatic test_stall_lhu();
    obs_t o; exp_t e;
    bus_ready_delay = 5; bus_rdata = 32'hFEDC0000;
    sb.push_back('{rd: 5'd12, data: 32'h0000FEDC, wen: 1'b1, err: 2'd0, lat: 8});
    drive_req(1, 3'd5, 32'h00000002, 32'h0, 5'd12);
    wait_wb(o);
    bus_ready_delay = 0;
    e = sb.pop_front();
    n_checks++;
    if ({o.stable, o.req_cycles} !== {1'b1, 32'd6})
      $display("FAIL stall_req: got stable=%b cycles=%0d exp stable=1 cycles=6", o.stable, o.req_cycles);
    else n_pass++;
    n_checks++;
    if ({o.lat, o.data, o.wb_wen, o.err} !== {e.lat, e.data, e.wen, e.err})
      $display("FAIL stall_wb: got lat=%0d data=%h wen=%b err=%0d exp lat=%0d data=%h wen=%b err=%0d",
               o.lat, o.data, o.wb_wen, o.err, e.lat, e.data, e.wen, e.err);
    else n_pass++;
  endtask

  task automatic test_bus_err();
    obs_t o; exp_t e;
    bus_err_i = 1; bus_rdata = 32'h12345678;
    sb.push_back('{rd: 5'd8, data: 32'h0, wen: 1'b0, err: 2'd3, lat: 3});
    drive_req(1, 3'd2, 32'h80000000, 32'h0, 5'd8);
    wait_wb(o);
    bus_err_i = 0;
    e = sb.pop_front();
    n_checks++;
    if ({o.lat, o.data, o.wb_wen, o.err} !== {e.lat, e.data, e.wen, e.err})
      $display("FAIL bus_err: got lat=%0d data=%h wen=%b err=%0d exp lat=%0d data=%h wen=%b err=%0d",
               o.lat, o.data, o.wb_wen, o.err, e.lat, e.data, e.wen, e.err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    bus_silent = 1;
    sb.push_back('{rd: 5'd11, data: 32'h0, wen: 1'b0, err: 2'd3, lat: 8});
    drive_req(1, 3'd2, 32'h80000010, 32'h0, 5'd11);
    wait_wb(o);
    e = sb.pop_front();
    n_checks++;
    if ({o.lat, o.err, o.data, o.wb_wen} !== {e.lat, e.err, e.data, e.wen})
      $display("FAIL timeout_wb: got lat=%0d err=%0d data=%h wen=%b exp lat=%0d err=%0d data=%h wen=%b",
               o.lat, o.err, o.data, o.wb_wen, e.lat, e.err, e.data, e.wen);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, wb_valid, req_ready} !== 3'b001)
      $display("FAIL timeout_after: got req=%b wb=%b ready=%b exp 0 0 1", mem_req_valid, wb_valid, req_ready);
    else n_pass++;
    bus_silent = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    bit saw_wb = 0;
    bus_rsp_delay = 3; bus_rdata = 32'hA5A5A5A5;
    drive_req(1, 3'd2, 32'h80000020, 32'h0, 5'd9);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, mem_req_valid, wb_valid} !== 3'b000)
      $display("FAIL rstmid_pre: got ready=%b req=%b wb=%b exp 000", req_ready, mem_req_valid, wb_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, mem_req_valid, wb_valid, wb_data} !== {3'b100, 32'h0})
      $display("FAIL rstmid_async: got ready=%b req=%b wb=%b data=%h exp 1 0 0 0", req_ready, mem_req_valid, wb_valid, wb_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_valid) saw_wb = 1;
    end
    n_checks++;
    if (saw_wb !== 1'b0) $display("FAIL rstmid_stale: got wb_valid seen=%b exp 0", saw_wb);
    else n_pass++;
    bus_rsp_delay = 0; bus_rdata = 32'h11223344;
    sb.push_back('{rd: 5'd7, data: 32'h11223344, wen: 1'b1, err: 2'd0, lat: 3});
    drive_req(1, 3'd2, 32'h80000004, 32'h0, 5'd7);
    wait_wb(o);
    e = sb.pop_front();
    n_checks++;
    if ({o.lat, o.data, o.wb_wen, o.rd, o.err} !== {e.lat, e.data, e.wen, e.rd, e.err})
      $display("FAIL rstmid_next: got lat=%0d data=%h wen=%b rd=%0d err=%0d exp lat=%0d data=%h wen=%b rd=%0d err=%0d",
               o.lat, o.data, o.wb_wen, o.rd, o.err, e.lat, e.data, e.wen, e.rd, e.err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    bus_rdata = 32'h9A000000;
    sb.push_back('{rd: 5'd1, data: 32'h0000009A, wen: 1'b1, err: 2'd0, lat: 3});
    drive_req(1, 3'd4, 32'h00000003, 32'h0, 5'd1);
    wait_wb(o);
    e = sb.pop_front();
    n_checks++;
    if ({o.lat, o.data, o.rd} !== {e.lat, e.data, e.rd})
      $display("FAIL b2b_first: got lat=%0d data=%h rd=%0d exp lat=%0d data=%h rd=%0d", o.lat, o.data, o.rd, e.lat, e.data, e.rd);
    else n_pass++;
    bus_rdata = 32'h0000F00F;
    sb.push_back('{rd: 5'd2, data: 32'hFFFFF00F, wen: 1'b1, err: 2'd0, lat: 3});
    drive_req(1, 3'd1, 32'h00000000, 32'h0, 5'd2);
    wait_wb(o);
    e = sb.pop_front();
    n_checks++;
    if ({o.lat, o.data, o.rd, o.wb_wen} !== {e.lat, e.data, e.rd, e.wen})
      $display("FAIL b2b_second: got lat=%0d data=%h rd=%0d wen=%b exp lat=%0d data=%h rd=%0d wen=%b",
               o.lat, o.data, o.rd, o.wb_wen, e.lat, e.data, e.rd, e.wen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_lb();
    test_store_lanes();
    test_load_ext();
    test_errors();
    test_stall_lhu();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
